// File: rtl/adc_sar_ctrl.sv
`default_nettype none
// ============================================================================
// adc_sar_ctrl : SAR ADC conversion sequencer (sample, per-bit settle/decide,
//                valid/ready result). Define ADC_SAR_COMP_SYNC_EN for a 2-flop
//                comparator synchroniser.                          Rev 1.0
// ============================================================================
module adc_sar_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             BUSY,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] DAC_CODE,
  input  logic             COMP,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_VALID,
  input  logic             DATA_READY
);

`ifdef ADC_SAR_COMP_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  localparam int SETTLE_LEN = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_MAX    = (SAMPLE_CYCLES > SETTLE_LEN) ? SAMPLE_CYCLES : SETTLE_LEN;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int IDX_W      = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMP   = 3'd1,
    S_SETTLE = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] trial;
  logic             comp_s;

`ifdef ADC_SAR_COMP_SYNC_EN
  logic comp_meta_q, comp_meta_d;
  logic comp_sync_q, comp_sync_d;

  always_comb begin
    comp_meta_d = COMP;
    comp_sync_d = comp_meta_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      comp_meta_q <= 1'b0;
      comp_sync_q <= 1'b0;
    end else begin
      comp_meta_q <= comp_meta_d;
      comp_sync_q <= comp_sync_d;
    end
  end

  assign comp_s = comp_sync_q;
`else
  assign comp_s = COMP;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    result_d   = result_q;
    data_out_d = data_out_q;
    trial      = result_q | (WIDTH'(1) << idx_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (START) state_d = S_SAMP;
      end
      S_SAMP: begin
        result_d = '0;
        idx_d    = IDX_MSB;
        if (cnt_q == SAMP_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DECIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECIDE: begin
        // Bit i is still clear in result_q, so COMP=0 simply leaves it clear.
        result_d = comp_s ? trial : result_q;
        if (idx_q == '0) begin
          state_d    = S_DONE;
          data_out_d = result_d;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        if (DATA_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the pins come straight off flops.
    dac_d    = '0;
    sample_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    valid_d  = (state_d == S_DONE);
    case (state_d)
      S_SAMP:            sample_d = 1'b1;
      S_SETTLE, S_DECIDE: dac_d   = result_d | (WIDTH'(1) << idx_d);
      S_DONE:            dac_d    = result_d;
      default:           dac_d    = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      data_out_q <= '0;
      dac_q      <= '0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      data_out_q <= data_out_d;
      dac_q      <= dac_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign BUSY       = busy_q;
  assign SAMPLE     = sample_q;
  assign DAC_CODE   = dac_q;
  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sar_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adc_sar_ctrl : scoreboard bench for the SAR conversion sequencer.
//                                                                  Rev 1.0
// ============================================================================
module tb_adc_sar_ctrl;
  localparam int WIDTH         = 10;
  localparam int SAMPLE_CYCLES = 4;
  localparam int SETTLE_CYCLES = 2;
`ifdef ADC_SAR_COMP_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  // DONE is entered LAT cycles after the START-sampling edge.
  localparam int LAT = 1 + SAMPLE_CYCLES + WIDTH * (SETTLE_CYCLES + S + 1);

  logic             CLK = 1'b0;
  logic             RESET, START, COMP, DATA_READY;
  logic             BUSY, SAMPLE, DATA_VALID;
  logic [WIDTH-1:0] DAC_CODE, DATA_OUT;

  int               comp_mode;
  logic [WIDTH-1:0] target;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               edge_cnt = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               start_edge;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] dac_log[$];

  adc_sar_ctrl #(
    .WIDTH(WIDTH), .SAMPLE_CYCLES(SAMPLE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .SAMPLE(SAMPLE),
    .DAC_CODE(DAC_CODE), .COMP(COMP), .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Comparator: 0 = held low, 1 = held high, 2 = behavioural (target >= DAC).
  assign COMP = (comp_mode == 0) ? 1'b0 :
                (comp_mode == 1) ? 1'b1 : (target >= DAC_CODE);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every rising DATA_VALID.
  initial begin : monitor
    exp_t e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev_valid = 1'b0;
      end else begin
        if (DATA_VALID && !prev_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("data_out", 32'(DATA_OUT), 32'(e.data));
            chk("valid_latency", 32'(edge_cnt - e.start_edge), 32'(LAT - 1));
          end
        end
        prev_valid = DATA_VALID;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after START is sampled.
  task automatic start_conv(input logic [WIDTH-1:0] exp_data);
    exp_t e;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    e.data       = exp_data;
    e.start_edge = edge_cnt;
    sb_q.push_back(e);
  endtask

  task automatic run_conv(input int mode, input logic [WIDTH-1:0] tgt,
                          input logic [WIDTH-1:0] exp, input int hold, input bit spam);
    int               waited;
    int               samp_cnt;
    logic [WIDTH-1:0] prev_dac;
    comp_mode = mode;
    target    = tgt;
    dac_log.delete();
    start_conv(exp);
    chk("sample_first_cycle", 32'(SAMPLE), 32'd1);
    samp_cnt = 0;
    prev_dac = '0;
    waited   = 0;
    while (!DATA_VALID && waited < 4 * LAT) begin
      samp_cnt += int'(SAMPLE);
      if (BUSY && DAC_CODE != prev_dac) dac_log.push_back(DAC_CODE);
      prev_dac = DAC_CODE;
      START = spam && (waited % 3 == 0);
      @(negedge CLK);
      waited++;
    end
    START = 1'b0;
    if (!DATA_VALID) chk("valid_timeout", 32'd0, 32'd1);
    chk("sample_cycles", 32'(samp_cnt), 32'(SAMPLE_CYCLES));
    for (int k = 0; k < hold; k++) begin
      chk("backpressure_hold", {21'd0, DATA_VALID, DATA_OUT}, {21'd0, 1'b1, exp});
      @(negedge CLK);
    end
    DATA_READY = 1'b1;
    START      = spam;
    @(negedge CLK);
    DATA_READY = 1'b0;
    START      = 1'b0;
    chk("valid_after_ack", 32'(DATA_VALID), 32'd0);
    chk("busy_after_ack", 32'(BUSY), 32'd0);
    chk("data_hold_after_ack", 32'(DATA_OUT), 32'(exp));
    repeat (3) begin
      @(negedge CLK);
      chk("no_restart", 32'(BUSY), 32'd0);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, BUSY, SAMPLE, DATA_VALID, DAC_CODE, DATA_OUT};
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] exp_trial;
    logic [31:0] got_trial;
    RESET      = 1'b1;
    START      = 1'b0;
    DATA_READY = 1'b0;
    comp_mode  = 1;
    target     = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", all_outs(), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    DATA_READY = 1'b1;
    @(negedge CLK);
    DATA_READY = 1'b0;
    chk("ready_in_idle", 32'(BUSY), 32'd0);

    // All ones, then all zeros with the trial-code sequence captured.
    run_conv(1, '0, 10'h3FF, 0, 1'b0);
    run_conv(0, '0, 10'h000, 0, 1'b0);
    chk("dac_trial_count", 32'(dac_log.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      exp_trial = 32'h200 >> k;
      got_trial = (k < dac_log.size()) ? 32'(dac_log[k]) : 32'hFFFF_FFFF;
      chk("dac_trial", got_trial, exp_trial);
    end

    // Behavioural comparator with 10 cycles of backpressure.
    run_conv(2, 10'h2A5, 10'h2A5, 10, 1'b0);
    // START hammered during the conversion and at the handshake.
    run_conv(2, 10'h15A, 10'h15A, 2, 1'b1);

    // Abort at cycle 20, reset through cycle 25, fresh conversion afterwards.
    comp_mode = 2;
    target    = 10'h2A5;
    start_conv(10'h2A5);
    repeat (19) @(negedge CLK);
    RESET = 1'b1;
    sb_q.delete();
    #1;
    chk("abort_reset_outputs", all_outs(), 32'd0);
    repeat (5) begin
      @(negedge CLK);
      chk("abort_reset_outputs", all_outs(), 32'd0);
    end
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    run_conv(2, 10'h2A5, 10'h2A5, 0, 1'b0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_sar_ctrl.md
Name: adc_sar_ctrl

Overview:
- Digital successive-approximation (SAR) conversion controller. It sits directly behind an analog pad: the pad's node feeds an external sample/hold, capacitive DAC and comparator.
- The block sequences sampling, drives the trial DAC code, reads the comparator decision and presents the converted word on a valid/ready handshake.
- It is the digital consumer of the analog pad signal chain in the SoC pad ring.

Parameters:
- WIDTH, 10, result/DAC code width; legal range 4..16.
- SAMPLE_CYCLES, 4, cycles SAMPLE is held high; must be >=1.
- SETTLE_CYCLES, 2, DAC settling cycles per bit before the comparator decision; must be >=1.

Ports:
- CLK  input  1  single clock for the block; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  conversion request; single-cycle pulse or level.
- BUSY  output  1  high in every state except IDLE.
- SAMPLE  output  1  sample/hold switch enable to the analog front end.
- DAC_CODE  output  WIDTH  trial code to the capacitive DAC.
- COMP  input  1  comparator result; 1 = analog input >= DAC level; asynchronous to CLK.
- DATA_OUT  output  WIDTH  converted result.
- DATA_VALID  output  1  result available.
- DATA_READY  input  1  consumer accepts result.

Behaviour:
- Reset: while RESET is high, state=IDLE and every output is 0 (BUSY, SAMPLE, DAC_CODE, DATA_OUT, DATA_VALID, internal counters and result register). Assertion mid-conversion aborts immediately. No partial result is ever presented.
- States: IDLE, SAMP, SETTLE, DECIDE, DONE.
- IDLE:
  - DAC_CODE=0.
  - START=1 sampled at edge N -> SAMP from cycle N+1.
  - START is ignored in all other states; no queueing.
- SAMP:
  - SAMPLE=1 for exactly SAMPLE_CYCLES cycles.
  - Result register cleared; bit index i=WIDTH-1.
  - Then -> SETTLE.
- SETTLE:
  - DAC_CODE = result | (1<<i) for the whole bit window.
  - Duration SETTLE_CYCLES+S cycles, where S is the synchroniser depth (see Optional Feature).
  - Then -> DECIDE.
- DECIDE:
  - One cycle; samples the (synchronised) comparator.
  - COMP=1 keeps bit i set in the result; COMP=0 clears it.
  - i>0 -> i-=1, -> SETTLE. i==0 -> DONE.
- Per-bit window = SETTLE_CYCLES+S+1 cycles.
- Latency: DONE is entered at cycle N+1+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+S+1). With defaults and S=2, this is N+55.
- DONE:
  - DATA_VALID=1; DATA_OUT=result; DAC_CODE=result; BUSY=1.
  - DATA_OUT is stable while DATA_VALID=1 and DATA_READY=0 (backpressure unbounded).
  - DATA_VALID=1 and DATA_READY=1 at an edge -> IDLE next cycle, DATA_VALID=0. DATA_OUT holds its last value until the next DONE.
  - START in the same cycle as the handshake is ignored. A new conversion needs START while in IDLE; minimum one IDLE cycle between conversions.
- DATA_READY outside DONE has no effect.
- COMP toggling outside DECIDE sampling has no effect on the result.
- DAC_CODE and SAMPLE are registered outputs (glitch-free to the analog macro).

Optional Feature:
- Macro ADC_SAR_COMP_SYNC_EN.
- Defined:
  - COMP passes through a 2-flop synchroniser; S=2.
  - Synchroniser flops reset to 0.
- Undefined:
  - COMP is sampled directly in DECIDE; S=0. Per-bit window = SETTLE_CYCLES+1.
  - With defaults, DONE is entered at N+35.
  - Intended for a comparator clocked by CLK.
- Ports are identical in both builds.

Test Plan:
- COMP held 1, defaults, sync enabled; START pulse at cycle 0 -> SAMPLE high cycles 1-4, DATA_VALID rises cycle 55, DATA_OUT=0x3FF.
- COMP held 0 -> DATA_OUT=0x000; DAC_CODE trial sequence 0x200, 0x100, 0x080 ... 0x001.
- Behavioural comparator model, COMP = (0x2A5 >= DAC_CODE) -> DATA_OUT=0x2A5; without ADC_SAR_COMP_SYNC_EN, DATA_VALID rises at cycle 35.
- DATA_READY low for 10 cycles after DATA_VALID -> DATA_OUT/DATA_VALID stable throughout. DATA_READY=1 -> DATA_VALID=0 and BUSY=0 the next cycle.
- START pulsed repeatedly during conversion and at the DONE handshake -> exactly one conversion, no restart.
- RESET asserted at cycle 20 of a conversion, released at 25, START at 30 -> all outputs 0 during reset. Fresh conversion completes normally with the correct 0x2A5 result.
